// File: rtl/jc_block_nested.sv
// Jump/interrupt control: jump decode, N prioritised edge-triggered nested irqs, return stack.
// Latency: every decision is taken on the edge that samples op/irq and is visible one cycle later.
// Backpressure: no accept while the stack is full or irq_en=0; pending irqs are held, never dropped.
//
// Ports:
//   clk, reset                   clock (rising edge), asynchronous active-high reset
//   jmp_address_pm               jump target from program memory
//   current_address, op, flag_ex instruction address, opcode and execute-stage flags (bit0 Z, bit1 C)
//   irq, irq_en                  interrupt request lines (index 0 highest priority), global enable
//   jmp_loc, pc_mux_sel          PC redirect target and single-cycle redirect strobe
//   flag_restore, flag_out       single-cycle flag reload request and the popped flags
//   in_service                   level currently in service, N_IRQ when idle
//   stack_full, err_underflow    all return entries used; sticky RET-on-empty error
module jc_block_nested #(
  parameter int                ADDR_W    = 16,
  parameter int                OP_W      = 6,
  parameter int                FLAG_W    = 2,
  parameter int                N_IRQ     = 4,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] ISR_BASE  = 16'hF000,
  parameter int                ISR_SHIFT = 4,
  parameter logic [OP_W-1:0]   OP_JMP    = 6'h18,
  parameter logic [OP_W-1:0]   OP_JZ     = 6'h10,
  parameter logic [OP_W-1:0]   OP_JNZ    = 6'h11,
  parameter logic [OP_W-1:0]   OP_JC     = 6'h12,
  parameter logic [OP_W-1:0]   OP_RET    = 6'h1E,
  localparam int               LVL_W     = $clog2(N_IRQ + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] jmp_address_pm,
  input  logic [ADDR_W-1:0] current_address,
  input  logic [OP_W-1:0]   op,
  input  logic [FLAG_W-1:0] flag_ex,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              irq_en,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              pc_mux_sel,
  output logic              flag_restore,
  output logic [FLAG_W-1:0] flag_out,
  output logic [LVL_W-1:0]  in_service,
  output logic              stack_full,
  output logic              err_underflow
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N_IRQ-1:0]  irq_q;
  logic [N_IRQ-1:0]  pending;
  logic [N_IRQ-1:0]  pend_eff;
  logic [SP_W-1:0]   sp;

  logic [ADDR_W-1:0] ret_mem  [DEPTH];
  logic [FLAG_W-1:0] flag_mem [DEPTH];
  logic [LVL_W-1:0]  lvl_mem  [DEPTH];

  logic              is_ret;
  logic              taken;
  logic              irq_hit;
  logic [LVL_W-1:0]  irq_idx;
  logic              accept;
  logic              do_pop;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] vector;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  top_idx;

  always_comb begin
    // An edge seen this cycle is eligible immediately, not one cycle later.
    pend_eff = pending | (irq & ~irq_q);
    is_ret   = (op == OP_RET);
    taken    = (op == OP_JMP)
             | ((op == OP_JZ)  &  flag_ex[0])
             | ((op == OP_JNZ) & ~flag_ex[0])
             | ((op == OP_JC)  &  flag_ex[1]);

    // Descending scan so the lowest eligible index is the one left standing.
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_eff[i] && (i < int'(in_service))) begin
        irq_hit = 1'b1;
        irq_idx = LVL_W'(i);
      end
    end

    // RET owns the cycle; an irq that would have been eligible is re-tried
    // next cycle against the restored level.
    accept   = irq_hit & irq_en & ~stack_full & ~is_ret;
    do_pop   = is_ret & (sp != '0);

    // A jump taken alongside an accept becomes the return address.
    ret_addr = taken ? jmp_address_pm : (current_address + ADDR_W'(1));
    vector   = ISR_BASE + (ADDR_W'(irq_idx) << ISR_SHIFT);
    push_idx = PTR_W'(sp);
    top_idx  = PTR_W'(sp - SP_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q         <= '0;
      pending       <= '0;
      sp            <= '0;
      jmp_loc       <= '0;
      pc_mux_sel    <= 1'b0;
      flag_restore  <= 1'b0;
      flag_out      <= '0;
      in_service    <= LVL_W'(N_IRQ);
      stack_full    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      irq_q        <= irq;
      pc_mux_sel   <= 1'b0;
      flag_restore <= 1'b0;
      pending      <= accept ? (pend_eff & ~(N_IRQ'(1) << irq_idx)) : pend_eff;

      if (do_pop) begin
        sp           <= sp - SP_W'(1);
        jmp_loc      <= ret_mem[top_idx];
        flag_out     <= flag_mem[top_idx];
        in_service   <= lvl_mem[top_idx];
        pc_mux_sel   <= 1'b1;
        flag_restore <= 1'b1;
        stack_full   <= 1'b0;
      end else if (is_ret) begin
        err_underflow <= 1'b1;
      end else if (accept) begin
        sp         <= sp + SP_W'(1);
        jmp_loc    <= vector;
        in_service <= irq_idx;
        pc_mux_sel <= 1'b1;
        stack_full <= (sp == SP_W'(DEPTH - 1));
      end else if (taken) begin
        jmp_loc    <= jmp_address_pm;
        pc_mux_sel <= 1'b1;
      end
    end
  end

  // Stack storage needs no reset: the stack pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      ret_mem[push_idx]  <= ret_addr;
      flag_mem[push_idx] <= flag_ex;
      lvl_mem[push_idx]  <= in_service;
    end
  end

endmodule

// File: tb/tb_jc_block_nested.sv
module tb_jc_block_nested;

  localparam logic [5:0] JMP = 6'h18, JZ = 6'h10, JNZ = 6'h11, JC = 6'h12, RET = 6'h1E, NOP = 6'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] jmp_address_pm, current_address, jmp_loc;
  logic [5:0]  op;
  logic [1:0]  flag_ex, flag_out;
  logic [3:0]  irq;
  logic        irq_en, pc_mux_sel, flag_restore, stack_full, err_underflow;
  logic [2:0]  in_service;

  int n_checks = 0;
  int n_fail   = 0;

  jc_block_nested dut (
    .clk(clk), .reset(reset), .jmp_address_pm(jmp_address_pm),
    .current_address(current_address), .op(op), .flag_ex(flag_ex),
    .irq(irq), .irq_en(irq_en), .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel),
    .flag_restore(flag_restore), .flag_out(flag_out), .in_service(in_service),
    .stack_full(stack_full), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural reference: return stack as a queue, priority as integers.
  typedef struct {
    logic [15:0] ret;
    logic [1:0]  fl;
    int          lvl;
  } ent_t;

  ent_t        m_stk[$];
  int          m_lvl;
  bit   [3:0]  m_pend, m_prev;
  logic        m_sel, m_rst, m_err;
  logic [15:0] m_loc;
  logic [1:0]  m_fout;

  task automatic model_reset();
    m_stk.delete();
    m_lvl = 4; m_pend = '0; m_prev = '0;
    m_sel = 0; m_rst = 0; m_err = 0; m_loc = '0; m_fout = '0;
  endtask

  task automatic model_step();
    int   best;
    logic tk;
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
      m_prev[i] = irq[i];
    end
    m_sel = 0; m_rst = 0;
    tk = (op == JMP) || (op == JZ && flag_ex[0]) || (op == JNZ && !flag_ex[0]) || (op == JC && flag_ex[1]);
    if (op == RET) begin
      if (m_stk.size() > 0) begin
        e = m_stk.pop_back();
        m_loc = e.ret; m_fout = e.fl; m_lvl = e.lvl; m_sel = 1; m_rst = 1;
      end else begin
        m_err = 1;
      end
    end else begin
      best = -1;
      if (irq_en && m_stk.size() < 4)
        for (int i = 3; i >= 0; i--)
          if (m_pend[i] && i < m_lvl) best = i;
      if (best >= 0) begin
        e.ret = tk ? jmp_address_pm : 16'(current_address + 16'd1);
        e.fl  = flag_ex;
        e.lvl = m_lvl;
        m_stk.push_back(e);
        m_loc = 16'hF000 + 16'(best * 16);
        m_lvl = best; m_pend[best] = 1'b0; m_sel = 1;
      end else if (tk) begin
        m_loc = jmp_address_pm; m_sel = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_sel",   32'(pc_mux_sel),    32'(m_sel));
    chk("m_loc",   32'(jmp_loc),       32'(m_loc));
    chk("m_frst",  32'(flag_restore),  32'(m_rst));
    chk("m_fout",  32'(flag_out),      32'(m_fout));
    chk("m_lvl",   32'(in_service),    32'(m_lvl));
    chk("m_full",  32'(stack_full),    32'(m_stk.size() == 4));
    chk("m_err",   32'(err_underflow), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step();
    model_step();
    tick();
    compare_model();
  endtask

  task automatic exp_redir(input string name, input logic [15:0] loc);
    chk({name, "_sel"}, 32'(pc_mux_sel), 32'd1);
    chk({name, "_loc"}, 32'(jmp_loc), 32'(loc));
  endtask

  task automatic exp_none(input string name);
    chk({name, "_sel"}, 32'(pc_mux_sel), 32'd0);
  endtask

  task automatic set_in(input logic [5:0] o, input logic [15:0] pm, input logic [15:0] cur,
                        input logic [1:0] f, input logic [3:0] q);
    op = o; jmp_address_pm = pm; current_address = cur; flag_ex = f; irq = q;
  endtask

  task automatic reset_check(input string name);
    chk({name, "_sel"},  32'(pc_mux_sel),    32'd0);
    chk({name, "_lvl"},  32'(in_service),    32'd4);
    chk({name, "_loc"},  32'(jmp_loc),       32'd0);
    chk({name, "_frst"}, 32'(flag_restore),  32'd0);
    chk({name, "_fout"}, 32'(flag_out),      32'd0);
    chk({name, "_full"}, 32'(stack_full),    32'd0);
    chk({name, "_err"},  32'(err_underflow), 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [15:0] pm;
    logic [1:0]  fl;
    logic        exp_sel;
    logic [15:0] exp_loc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{JMP,   16'h0008, 2'b00, 1'b1, 16'h0008};
    vecs[1] = '{JZ,    16'h0100, 2'b00, 1'b0, 16'h0000};
    vecs[2] = '{JZ,    16'h0110, 2'b01, 1'b1, 16'h0110};
    vecs[3] = '{JNZ,   16'h0200, 2'b01, 1'b0, 16'h0000};
    vecs[4] = '{JNZ,   16'h0210, 2'b00, 1'b1, 16'h0210};
    vecs[5] = '{JC,    16'h0300, 2'b01, 1'b0, 16'h0000};
    vecs[6] = '{JC,    16'h0310, 2'b10, 1'b1, 16'h0310};
    vecs[7] = '{NOP,   16'h0400, 2'b11, 1'b0, 16'h0000};
    vecs[8] = '{6'h19, 16'h0500, 2'b11, 1'b0, 16'h0000};
    vecs[9] = '{JMP,   16'hFFFF, 2'b11, 1'b1, 16'hFFFF};

    // 1. reset held while irq toggles
    reset = 1'b1; irq_en = 1'b1;
    set_in(NOP, 16'h0, 16'h0, 2'b00, 4'h0);
    for (int i = 0; i < 4; i++) begin
      irq = 4'($urandom_range(0, 15));
      tick();
      reset_check("rst_hold");
    end
    irq = 4'h0;
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      exp_none("post_rst");
    end

    // 2. jump decode table
    foreach (vecs[i]) begin
      set_in(vecs[i].op, vecs[i].pm, 16'h0030, vecs[i].fl, 4'h0);
      step();
      chk("tbl_sel", 32'(pc_mux_sel), 32'(vecs[i].exp_sel));
      chk("tbl_frst", 32'(flag_restore), 32'd0);
      if (vecs[i].exp_sel) chk("tbl_loc", 32'(jmp_loc), 32'(vecs[i].exp_loc));
    end

    // 3. single irq and return
    set_in(NOP, 16'h0, 16'h0001, 2'b01, 4'b0100);
    step(); exp_redir("irq2", 16'hF020);
    chk("irq2_lvl", 32'(in_service), 32'd2);
    flag_ex = 2'b10;
    step(); exp_none("lvl_no_rearm");
    op = RET;
    step(); exp_redir("ret1", 16'h0002);
    chk("ret1_frst", 32'(flag_restore), 32'd1);
    chk("ret1_fout", 32'(flag_out), 32'd1);
    chk("ret1_lvl", 32'(in_service), 32'd4);
    op = NOP;
    step(); exp_none("ret1_after");
    chk("frst_pulse", 32'(flag_restore), 32'd0);
    irq = 4'h0;
    step();

    // 4. nesting
    set_in(NOP, 16'h0, 16'h0010, 2'b00, 4'b0100);
    step(); exp_redir("n_irq2", 16'hF020);
    set_in(NOP, 16'h0, 16'h0020, 2'b00, 4'b1100);
    step(); exp_none("n_irq3_held");
    set_in(NOP, 16'h0, 16'h0030, 2'b11, 4'b1101);
    step(); exp_redir("n_irq0", 16'hF000);
    chk("n_irq0_lvl", 32'(in_service), 32'd0);
    op = RET;
    step(); exp_redir("n_ret0", 16'h0031);
    op = NOP;
    step(); exp_none("n_irq3_still_held");
    op = RET;
    step(); exp_redir("n_ret2", 16'h0011);
    set_in(NOP, 16'h0, 16'h0050, 2'b00, 4'b1101);
    step(); exp_redir("n_irq3", 16'hF030);
    op = RET;
    step(); exp_redir("n_ret3", 16'h0051);
    set_in(NOP, 16'h0, 16'h0, 2'b00, 4'h0);
    step();

    // 6. irq accepted together with a taken jump
    set_in(JMP, 16'h0040, 16'h0060, 2'b11, 4'b0010);
    step(); exp_redir("jirq", 16'hF010);
    set_in(RET, 16'h0, 16'h0, 2'b00, 4'h0);
    step(); exp_redir("jirq_ret", 16'h0040);
    chk("jirq_fout", 32'(flag_out), 32'd3);
    op = NOP;
    step();

    // reset in the middle of an ISR with a held pending irq
    irq = 4'b0010;
    step(); exp_redir("mid_irq1", 16'hF010);
    irq_en = 1'b0; irq = 4'b0001;
    step(); exp_none("mid_held");
    irq = 4'h0;
    step();
    reset = 1'b1; #1;
    reset_check("mid_rst_async");
    tick(); tick();
    reset_check("mid_rst");
    reset = 1'b0; irq_en = 1'b1;
    model_reset();
    step(); exp_none("pend_lost0");
    step(); exp_none("pend_lost1");
    op = RET;
    step(); exp_none("uflow");
    chk("uflow_err", 32'(err_underflow), 32'd1);
    op = NOP;
    step(); chk("uflow_sticky", 32'(err_underflow), 32'd1);
    reset = 1'b1; tick(); tick();
    reset_check("err_clr");
    reset = 1'b0;
    model_reset();

    // 5. fill the stack, hold a pending, drain past empty
    set_in(NOP, 16'h0, 16'h0100, 2'b00, 4'b1000);
    step(); exp_redir("f3", 16'hF030);
    set_in(NOP, 16'h0, 16'h0200, 2'b01, 4'b1100);
    step(); exp_redir("f2", 16'hF020);
    set_in(NOP, 16'h0, 16'h0300, 2'b10, 4'b1110);
    step(); exp_redir("f1", 16'hF010);
    chk("f1_notfull", 32'(stack_full), 32'd0);
    set_in(NOP, 16'h0, 16'h0400, 2'b11, 4'b1111);
    step(); exp_redir("f0", 16'hF000);
    chk("full", 32'(stack_full), 32'd1);
    chk("full_lvl", 32'(in_service), 32'd0);
    irq = 4'h0; irq_en = 1'b0;
    step();
    irq = 4'b1000;
    step(); exp_none("f_pend_held");
    op = RET;
    step(); exp_redir("fr0", 16'h0401);
    chk("fr0_full", 32'(stack_full), 32'd0);
    step(); exp_redir("fr1", 16'h0301);
    step(); exp_redir("fr2", 16'h0201);
    step(); exp_redir("fr3", 16'h0101);
    chk("fr3_lvl", 32'(in_service), 32'd4);
    step(); exp_none("fr4_uflow");
    chk("fr4_err", 32'(err_underflow), 32'd1);
    set_in(NOP, 16'h0, 16'h0500, 2'b00, 4'b1000);
    irq_en = 1'b1;
    step(); exp_redir("en_accept", 16'hF030);
    op = RET;
    step(); exp_redir("en_ret", 16'h0501);
    set_in(NOP, 16'h0, 16'h0, 2'b00, 4'h0);
    step();

    // randomized run against the reference model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: op = JMP;
        1: op = JZ;
        2: op = JNZ;
        3: op = JC;
        4: op = RET;
        default: op = 6'($urandom_range(0, 63));
      endcase
      jmp_address_pm  = 16'($urandom);
      current_address = 16'($urandom);
      flag_ex         = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      irq_en = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
